// File: rtl/number_finder.sv
// number_finder: scans candidates 0..31 and offers, in ascending order, every
// candidate whose divisibility property vector equals the latched pattern.
// Each match is offered with a valid/ready handshake. A one-cycle done pulse
// marks the end of the scan.
// Optional feature: define MATCH_COUNT_EN to add the match_count port, which
// counts the matches accepted in the current or last scan.
module number_finder (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] pattern,
  input  logic       start,
  output logic [4:0] num_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
`ifdef MATCH_COUNT_EN
  ,
  output logic [5:0] match_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t     state_r;
  logic [4:0] cand_r;
  logic [4:0] pat_r;
  logic       match_s;
  logic       last_s;

  // Property vector of candidate n:
  // bit4 = even, bit3 = mult of 3, bit2 = mult of 4, bit1 = mult of 5,
  // bit0 = mult of 30. Zero is a multiple of everything, so it gives 5'b11111.
  function automatic logic [4:0] props(input logic [4:0] n);
    logic [4:0] p;
    p[4] = ((n % 5'd2)  == 5'd0);
    p[3] = ((n % 5'd3)  == 5'd0);
    p[2] = ((n % 5'd4)  == 5'd0);
    p[1] = ((n % 5'd5)  == 5'd0);
    p[0] = ((n % 5'd30) == 5'd0);
    return p;
  endfunction

  // Match and end-of-range decode for the current candidate.
  always_comb begin
    match_s = (props(cand_r) == pat_r);
    last_s  = (cand_r == 5'd31);
  end

  // Scan controller. All outputs are registered. done rises in the cycle after
  // FIN, which is the first IDLE cycle, with busy already low. The candidate
  // counter is only incremented when it is below 31, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cand_r      <= 5'd0;
      pat_r       <= 5'd0;
      num_out     <= 5'd0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
`ifdef MATCH_COUNT_EN
      match_count <= 6'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            pat_r   <= pattern;
            cand_r  <= 5'd0;
            busy    <= 1'b1;
            state_r <= SCAN;
`ifdef MATCH_COUNT_EN
            match_count <= 6'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (match_s) begin
            num_out   <= cand_r;
            out_valid <= 1'b1;
            state_r   <= HOLD;
          end else if (last_s) begin
            state_r <= FIN;
          end else begin
            cand_r <= cand_r + 5'd1;
          end
        end
        HOLD: begin
          // num_out and out_valid are untouched until the consumer accepts.
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef MATCH_COUNT_EN
            match_count <= match_count + 6'd1;
`endif
            if (last_s) begin
              state_r <= FIN;
            end else begin
              cand_r  <= cand_r + 5'd1;
              state_r <= SCAN;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_number_finder.sv
// Scoreboard bench for number_finder. Each test pushes its expected outputs
// (matching numbers, then a done marker) into a queue. A monitor pops and
// compares on every accepted handshake and on every done pulse.
module tb_number_finder;

  logic       clk;
  logic       reset;
  logic [4:0] pattern;
  logic       start;
  logic [4:0] num_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef MATCH_COUNT_EN
  logic [5:0] match_count;
`endif

  number_finder dut (
    .clk        (clk),
    .reset      (reset),
    .pattern    (pattern),
    .start      (start),
    .num_out    (num_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
`ifdef MATCH_COUNT_EN
    ,
    .match_count(match_count)
`endif
  );

  typedef struct packed {
    logic       is_done;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   t0       = 0;
  int   first_edge = 0;
  int   done_edge  = 0;
  int   done_cnt   = 0;
  bit   got_first  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_val(input logic [4:0] v);
    exp_t e;
    e.is_done = 1'b0;
    e.val     = v;
    sb.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.val     = 5'd0;
    sb.push_back(e);
  endtask

  // Edge counter used for latency measurements.
  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Monitor: sample on the falling edge, away from the active edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (out_valid && !got_first) begin
        got_first  = 1'b1;
        first_edge = edge_cnt;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {27'd0, num_out}, 32'd99);
        end else begin
          e = sb.pop_front();
          check("sb_kind_value", {31'd0, e.is_done}, 32'd0);
          check("sb_value", {27'd0, num_out}, {27'd0, e.val});
        end
      end
      if (done) begin
        done_cnt++;
        done_edge = edge_cnt;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_kind_done", {31'd0, e.is_done}, 32'd1);
        end
      end
    end
  end

  task automatic do_start(input logic [4:0] p);
    @(posedge clk);
    #1;
    pattern = p;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    t0        = edge_cnt;
    got_first = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int s;
    bit seen;
    s    = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != s) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("valid_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saved;
    reset     = 1'b1;
    pattern   = 5'd0;
    start     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_num_out", {27'd0, num_out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef MATCH_COUNT_EN
    check("rst_match_count", {26'd0, match_count}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Pattern 11111: only candidate 0 matches.
    push_val(5'd0);
    push_done();
    do_start(5'b11111);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(100);
    check("lat_first_0", first_edge - t0, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef MATCH_COUNT_EN
    check("mc_11111", {26'd0, match_count}, 32'd1);
`endif

    // Pattern 10100 with a start pulse during the scan that must be ignored.
    push_val(5'd4);
    push_val(5'd8);
    push_val(5'd16);
    push_val(5'd28);
    push_done();
    do_start(5'b10100);
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_scan", {31'd0, busy}, 32'd1);
    pattern = 5'b11111;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100);
    check("lat_first_4", first_edge - t0, 32'd5);
`ifdef MATCH_COUNT_EN
    check("mc_10100", {26'd0, match_count}, 32'd4);
`endif

    // Pattern 00010 with backpressure on the first offer.
    out_ready = 1'b0;
    push_val(5'd5);
    push_val(5'd25);
    push_done();
    do_start(5'b00010);
    wait_valid(100);
    check("lat_first_5", first_edge - t0, 32'd6);
    for (int i = 0; i < 5; i++) begin
      check("hold_num_out", {27'd0, num_out}, 32'd5);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(100);
`ifdef MATCH_COUNT_EN
    check("mc_00010", {26'd0, match_count}, 32'd2);
`endif

    // Pattern 00001 matches nothing: done 33 cycles after the accepted start.
    push_done();
    do_start(5'b00001);
    wait_done(100);
    check("done_lat_nomatch", done_edge - t0, 32'd33);
    check("nomatch_no_valid", {31'd0, got_first}, 32'd0);
`ifdef MATCH_COUNT_EN
    check("mc_00001", {26'd0, match_count}, 32'd0);
`endif

    // Pattern 01000, reset while offering 3, then a clean rescan.
    out_ready = 1'b0;
    do_start(5'b01000);
    wait_valid(100);
    check("offer_before_reset", {27'd0, num_out}, 32'd3);
    saved = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_num_out", {27'd0, num_out}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, saved);
    out_ready = 1'b1;
    push_val(5'd3);
    push_val(5'd9);
    push_val(5'd21);
    push_val(5'd27);
    push_done();
    do_start(5'b01000);
    wait_done(100);
    check("lat_first_3", first_edge - t0, 32'd4);
`ifdef MATCH_COUNT_EN
    check("mc_01000", {26'd0, match_count}, 32'd4);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
